// File: rtl/frame_pixel_streamer.sv
// Raster-order frame renderer: snapshots sprite positions on request, then streams every
// pixel as RGB888 over valid/ready with doodle > block > background priority.
module frame_pixel_streamer #(
  parameter int unsigned SCREEN_WIDTH  = 64,
  parameter int unsigned SCREEN_HEIGHT = 128,
  parameter int unsigned NUM_BLOCKS    = 8,
  parameter int unsigned BLOCK_W       = 12,
  parameter int unsigned BLOCK_H       = 3,
  parameter int unsigned DOODLE_W      = 8,
  parameter int unsigned DOODLE_H      = 8,
  parameter int unsigned COORD_W       = 16,
  parameter logic [23:0] BG_COLOR      = 24'hFFFFFF,
  parameter logic [23:0] DOODLE_COLOR  = 24'h08FF08,
  parameter logic [23:0] BLOCK_COLOR   = 24'h8B5A2B
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_req,
  input  logic [COORD_W-1:0]            doodle_x,
  input  logic [COORD_W-1:0]            doodle_y,
  input  logic [NUM_BLOCKS*COORD_W-1:0] blocks_x,
  input  logic [NUM_BLOCKS*COORD_W-1:0] blocks_y,
  input  logic [NUM_BLOCKS-1:0]         blocks_en,
  output logic                          busy,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [23:0]                   pix_data,
  output logic [COORD_W-1:0]            pix_x,
  output logic [COORD_W-1:0]            pix_y,
  output logic                          pix_sof,
  output logic                          pix_eol,
  output logic                          pix_eof,
  output logic                          frame_done
);

  typedef enum logic {StIdle, StActive} state_e;

  localparam logic [COORD_W-1:0] LastX   = COORD_W'(SCREEN_WIDTH - 1);
  localparam logic [COORD_W-1:0] LastY   = COORD_W'(SCREEN_HEIGHT - 1);
  localparam logic [COORD_W:0]   DoodleW = (COORD_W + 1)'(DOODLE_W);
  localparam logic [COORD_W:0]   DoodleH = (COORD_W + 1)'(DOODLE_H);
  localparam logic [COORD_W:0]   BlockW  = (COORD_W + 1)'(BLOCK_W);
  localparam logic [COORD_W:0]   BlockH  = (COORD_W + 1)'(BLOCK_H);

  state_e                        r_state, w_state_next;
  logic [COORD_W-1:0]            r_doodle_x, r_doodle_y;
  logic [NUM_BLOCKS*COORD_W-1:0] r_blocks_x, r_blocks_y;
  logic [NUM_BLOCKS-1:0]         r_blocks_en;
  logic [COORD_W-1:0]            r_x, r_y;
  logic                          r_pix_valid, r_pix_sof, r_pix_eol, r_pix_eof, r_frame_done;
  logic [23:0]                   r_pix_data;
  logic [COORD_W-1:0]            r_pix_x, r_pix_y;

  logic                          w_start, w_load, w_xfer, w_last_xfer, w_busy;
  logic                          w_doodle_hit, w_block_hit;
  logic [23:0]                   w_color;

  // Extended-width compare so sprites near the coordinate limit never wrap onto the screen.
  function automatic logic hit(input logic [COORD_W-1:0] sx, input logic [COORD_W-1:0] sy,
                               input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                               input logic [COORD_W:0] w, input logic [COORD_W:0] h);
    return (sx <= px) && ({1'b0, px} < ({1'b0, sx} + w)) &&
           (sy <= py) && ({1'b0, py} < ({1'b0, sy} + h));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (frame_req)   w_state_next = StActive;
      StActive: if (w_last_xfer) w_state_next = StIdle;
      default:                   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_busy      = (r_state == StActive);
    w_start     = (r_state == StIdle) && frame_req;
    w_xfer      = r_pix_valid && pix_ready;
    w_last_xfer = w_busy && w_xfer && r_pix_eof;
    // Fill the empty output register once, then refill on every non-final transfer.
    w_load      = w_busy && (!r_pix_valid || (w_xfer && !r_pix_eof));
  end

  always_comb begin
    w_doodle_hit = hit(r_doodle_x, r_doodle_y, r_x, r_y, DoodleW, DoodleH);
    w_block_hit  = 1'b0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      if (r_blocks_en[i] && hit(r_blocks_x[i*COORD_W +: COORD_W],
                                r_blocks_y[i*COORD_W +: COORD_W], r_x, r_y, BlockW, BlockH)) begin
        w_block_hit = 1'b1;
      end
    end
    if (w_doodle_hit)     w_color = DOODLE_COLOR;
    else if (w_block_hit) w_color = BLOCK_COLOR;
    else                  w_color = BG_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_doodle_x  <= '0;
      r_doodle_y  <= '0;
      r_blocks_x  <= '0;
      r_blocks_y  <= '0;
      r_blocks_en <= '0;
    end else if (w_start) begin
      r_doodle_x  <= doodle_x;
      r_doodle_y  <= doodle_y;
      r_blocks_x  <= blocks_x;
      r_blocks_y  <= blocks_y;
      r_blocks_en <= blocks_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_load) begin
      if (r_x == LastX) begin
        r_x <= '0;
        r_y <= r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_sof    <= 1'b0;
      r_pix_eol    <= 1'b0;
      r_pix_eof    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_xfer;
      if (w_load) begin
        r_pix_valid <= 1'b1;
        r_pix_data  <= w_color;
        r_pix_x     <= r_x;
        r_pix_y     <= r_y;
        r_pix_sof   <= (r_x == '0) && (r_y == '0);
        r_pix_eol   <= (r_x == LastX);
        r_pix_eof   <= (r_x == LastX) && (r_y == LastY);
      end else if (w_last_xfer) begin
        r_pix_valid <= 1'b0;
      end
    end
  end

  assign busy       = w_busy;
  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign pix_sof    = r_pix_sof;
  assign pix_eol    = r_pix_eol;
  assign pix_eof    = r_pix_eof;
  assign frame_done = r_frame_done;

endmodule
